key_debounce_irq_ctrl: RTL and testbench
========================================

Name: key_debounce_irq_ctrl

Overview:
- Avalon-MM slave controller for the push-button keys on the Qsys system.
- Synchronises and debounces the raw key inputs, then captures press edges into a sticky register.
- Raises a maskable interrupt to the Nios II.
- Sits between the board KEY pins and the CPU data master; a key-sampling port plus the control logic the CPU needs to service presses without polling.

Parameters:
- WIDTH, 4: number of key inputs (1..32).
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- address  input  2  Avalon register word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  Avalon write strobe, active-low.
- writedata  input  32  Avalon write data.
- in_port  input  WIDTH  raw key pins, active-low (0 = pressed), asynchronous to clk.
- readdata  output  32  Avalon read data, registered.
- irq  output  1  interrupt request, active-high, level.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on reset_n; all flops clear immediately on reset_n=0.
- Reset values:
  - synchroniser stages = all 1s;
  - debounced state = all 1s (keys released);
  - counters = 0, per-key FSM = STABLE;
  - edgecapture = 0, irqmask = 0;
  - readdata = 0, irq = 0.
- Synchroniser: 2-flop chain per bit; sync[i] is the second stage.
- Per-key FSM, independent per bit, 2 states:
  - STABLE: counter held at 0. If sync[i] != deb[i], go to COUNT and set counter = 1.
  - COUNT, when sync[i] == deb[i]: return to STABLE, counter = 0 (glitch rejected).
  - COUNT, when sync[i] != deb[i] and counter == DEBOUNCE_CYCLES-1: set deb[i] = sync[i], counter = 0, go to STABLE.
  - COUNT otherwise: counter increments.
  - Latency: a clean level change on in_port reaches deb after 2 + DEBOUNCE_CYCLES clk cycles. Any bounce restarts the window.
- Press detect: press[i] = deb_prev[i] & ~deb[i], i.e. a 1->0 transition of the debounced state. It is a one-cycle pulse.
- Register map (word addresses):
  - 0 DATA, RO: {zeros, ~deb}, so 1 = pressed. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK, RW: bits [WIDTH-1:0]; upper bits read 0.
  - 3 EDGECAPTURE, RW1C: a press sets the bit sticky. A write with writedata[i]=1 clears bit i; writing 0 has no effect.
- Write: occurs on chipselect=1 & write_n=0, taking effect on that clock edge.
- Simultaneous press pulse and clear-write on the same bit: set wins (bit ends at 1).
- Read: readdata is registered every cycle from the address mux, giving read latency 1. Unused upper bits are always 0.
- irq = |(edgecapture & irqmask), combinational from flops, so irq asserts in the cycle after a capture/mask update.
- Mid-operation reset: in-progress debounce windows are discarded and captured edges are lost. After release, a key still held low is seen as a new press after 2 + DEBOUNCE_CYCLES cycles.
- Counter wrap: not possible by construction; the counter saturates at DEBOUNCE_CYCLES-1 before reload.

Optional Feature:
- Macro: KEY_BOTH_EDGES_EN.
- Defined: press[i] = deb_prev[i] ^ deb[i], so both press and release set EDGECAPTURE bits. An additional register at address 1 (EDGEDIR, RO) holds the debounced level at the time of the last captured edge per bit (1 = press).
- Undefined: only presses (1->0) are captured, and address 1 reads 0.

Test Plan:
- Reset/idle, DEBOUNCE_CYCLES=4, in_port=4'hF: readdata=0 at all addresses, irq=0.
- Clean press: set irqmask=4'h1, drive in_port[0]=0.
  - DATA reads 0x1 after exactly 6 cycles.
  - EDGECAPTURE reads 0x1 and irq=1 one cycle later.
- Bounce rejection: in_port[1] toggles 0,1,0,1 with 2-cycle periods, then holds 0. DATA bit1 sets only 6 cycles after the final stable 0, and EDGECAPTURE bit1 is set exactly once.
- Clear vs set collision: write 0x1 to address 3 on the same edge as a new bit0 press pulse. EDGECAPTURE bit0 must remain 1.
- Mask and clear: EDGECAPTURE=0x5, irqmask=0x4 gives irq=1. Write 0x4 to address 3: irq=0 next cycle and EDGECAPTURE reads 0x1.
- Reset mid-window: assert reset_n=0 at count=2 while in_port[2]=0. Everything clears; after release DATA bit2 sets 6 cycles later.

Source files
------------

// File: rtl/key_debounce_irq_ctrl.sv
// key_debounce_irq_ctrl: Avalon-MM push-button controller.
// Synchronises and debounces the raw active-low key pins, captures press
// edges into a sticky RW1C register and raises a maskable level interrupt.
// Optional build macro KEY_BOTH_EDGES_EN: capture both press and release
// edges and expose the per-bit direction of the last edge at address 1.
module key_debounce_irq_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic {ST_STABLE, ST_COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_deb_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    state_t           r_state [WIDTH];
    logic [CNT_W-1:0] r_cnt   [WIDTH];
    logic [31:0]      r_readdata;

    state_t           w_state_nxt [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];
    logic [WIDTH-1:0] w_deb_nxt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    // Upper write-data bits are not stored when WIDTH < 32.
    assign w_unused_wdata = &{1'b0, writedata};

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

`ifdef KEY_BOTH_EDGES_EN
    assign w_edge = r_deb_prev ^ r_deb;
`else
    assign w_edge = r_deb_prev & ~r_deb;
`endif

    // Two-flop synchroniser for the asynchronous key pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce FSM state, counter and debounced level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
            r_deb      <= '1;
            r_deb_prev <= '1;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_deb      <= w_deb_nxt;
            r_deb_prev <= r_deb;
        end
    end

    // Per-key next state: any mismatch restarts a window, a full window accepts the level.
    always_comb begin
        w_deb_nxt = r_deb;
        for (int i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    w_cnt_nxt[i] = '0;
                    if (r_sync2[i] != r_deb[i]) begin
                        w_state_nxt[i] = ST_COUNT;
                        w_cnt_nxt[i]   = CNT_ONE;
                    end
                end
                ST_COUNT: begin
                    if (r_sync2[i] == r_deb[i]) begin
                        w_state_nxt[i] = ST_STABLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_deb_nxt[i]   = r_sync2[i];
                        w_state_nxt[i] = ST_STABLE;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_STABLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Mask register write and sticky edge capture; a same-cycle edge beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && address == 2'd2) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

`ifdef KEY_BOTH_EDGES_EN
    logic [WIDTH-1:0] r_edgedir;

    // Remember the debounced level of the last captured edge (1 = pressed).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgedir <= '0;
        end else begin
            r_edgedir <= (r_edgedir & ~w_edge) | (~r_deb & w_edge);
        end
    end
`endif

    // Read mux; unused upper bits stay zero.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0: w_rd_mux[WIDTH-1:0] = ~r_deb;
`ifdef KEY_BOTH_EDGES_EN
            2'd1: w_rd_mux[WIDTH-1:0] = r_edgedir;
`else
            2'd1: w_rd_mux = '0;
`endif
            2'd2: w_rd_mux[WIDTH-1:0] = r_irqmask;
            2'd3: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default: w_rd_mux = '0;
        endcase
    end

    // Registered read data, refreshed every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_key_debounce_irq_ctrl.sv
// Directed bench for key_debounce_irq_ctrl with DEBOUNCE_CYCLES=4.
module tb_key_debounce_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks;
    int n_fail;

    key_debounce_irq_ctrl #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        tick(1);
        check(tag, readdata, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Reset / idle
        tick(3);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rd", readdata, 32'd0);
        reset_n = 1'b1;
        tick(2);
        bus_read(2'd0, "idle_data", 32'd0);
        bus_read(2'd1, "idle_rsvd", 32'd0);
        bus_read(2'd2, "idle_mask", 32'd0);
        bus_read(2'd3, "idle_ecap", 32'd0);
        check("idle_irq", {31'd0, irq}, 32'd0);

        // Clean press on key 0: deb changes on edge 6, readdata on edge 7
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, "mask_rb", 32'h1);
        address = 2'd0;
        in_port = 4'hE;
        tick(6);
        check("press_data_early", readdata, 32'h0);
        check("press_irq_early", {31'd0, irq}, 32'd0);
        tick(1);
        check("press_data", readdata, 32'h1);
        check("press_irq", {31'd0, irq}, 32'd1);
        bus_read(2'd3, "press_ecap", 32'h1);

        // Bounce rejection on key 1
        address = 2'd0;
        in_port = 4'hC; tick(2);
        in_port = 4'hE; tick(2);
        in_port = 4'hC; tick(2);
        in_port = 4'hE; tick(2);
        check("bounce_data_held", readdata, 32'h1);
        in_port = 4'hC;
        tick(6);
        check("bounce_data_early", readdata, 32'h1);
        tick(1);
        check("bounce_data", readdata, 32'h3);
        bus_read(2'd3, "bounce_ecap", 32'h3);
        bus_write(2'd3, 32'h2);
        address = 2'd3;
        tick(10);
        check("bounce_once", readdata, 32'h1);

        // Clear all, release key 0 (no capture), then collide clear with a new press
        bus_write(2'd3, 32'h3);
        bus_read(2'd3, "clr_ecap", 32'h0);
        check("clr_irq", {31'd0, irq}, 32'd0);
        in_port = 4'hD;
        tick(8);
        bus_read(2'd3, "release_no_cap", 32'h0);
        bus_read(2'd0, "release_data", 32'h2);
        in_port = 4'hC;
        tick(6);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, "collide_ecap", 32'h1);
        check("collide_irq", {31'd0, irq}, 32'd1);

        // Mask and clear with EDGECAPTURE = 0x5
        in_port = 4'h8;
        tick(8);
        bus_read(2'd3, "ecap_5", 32'h5);
        bus_write(2'd2, 32'h4);
        check("mask4_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h4);
        check("clr4_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd3, "clr4_ecap", 32'h1);
        bus_read(2'd0, "data_7", 32'h7);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, "wr0_noeffect", 32'h1);

        // Reset mid-window on key 2
        bus_write(2'd2, 32'hF);
        in_port = 4'hF;
        tick(8);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        address = 2'd0;
        in_port = 4'hB;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_rd", readdata, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("post_rst_early", readdata, 32'h0);
        tick(1);
        check("post_rst_data", readdata, 32'h4);
        bus_read(2'd2, "post_rst_mask", 32'h0);
        bus_read(2'd3, "post_rst_ecap", 32'h4);
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
